// File: rtl/pipe_reg_chain_pkg.sv
// Shared definitions for the pipeline register chain.
//   RV_NOP      : default bubble payload (RV32I "addi x0,x0,0")
//   IF_ID..     : stage indices of the classic 4-register RISC pipeline
//   stage_sel_e : per-stage next-state select driven by the chain controller
package pipe_reg_chain_pkg;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  localparam int IF_ID  = 0;
  localparam int ID_EX  = 1;
  localparam int EX_MEM = 2;
  localparam int MEM_WB = 3;

  typedef enum logic [1:0] {
    SEL_LOAD   = 2'd0,
    SEL_HOLD   = 2'd1,
    SEL_BUBBLE = 2'd2
  } stage_sel_e;

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// One pipeline register stage: WIDTH payload bits plus a valid bit.
// Ports:
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   sel         : load from src / hold current / load bubble
//   src_data    : payload from the upstream stage (or the producer)
//   src_valid   : valid bit from upstream
//   data, valid : registered stage contents
module pipe_reg_chain_stage
  import pipe_reg_chain_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = WIDTH'(RV_NOP)
) (
  input  logic             clk,
  input  logic             reset,
  input  stage_sel_e       sel,
  input  logic [WIDTH-1:0] src_data,
  input  logic             src_valid,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  // Stage register with load/hold/bubble select.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data  <= BUBBLE_VAL;
      valid <= 1'b0;
    end else begin
      case (sel)
        SEL_LOAD: begin
          data  <= src_data;
          valid <= src_valid;
        end
        SEL_HOLD: begin
          data  <= data;
          valid <= valid;
        end
        SEL_BUBBLE: begin
          data  <= BUBBLE_VAL;
          valid <= 1'b0;
        end
        default: begin
          data  <= BUBBLE_VAL;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// Parametrised chain of STAGES pipeline registers with per-stage stall and flush,
// valid tracking, upstream stall propagation, automatic bubble insertion and
// saturating stall/bubble performance counters.
// Ports:
//   clk, reset            : rising-edge clock, asynchronous active-high reset
//   in_data, in_valid     : producer side entering stage 0
//   in_ready              : producer may advance (combinational, ~hold[0])
//   stall[i], flush[i]    : per-stage hold / squash requests from the hazard unit
//   cnt_clr               : synchronous clear of both counters
//   tap_data, tap_valid   : every stage's contents, stage i at [i*WIDTH +: WIDTH]
//   out_data, out_valid   : last stage contents
//   stall_cnt, bubble_cnt : saturating event counters
module pipe_reg_chain
  import pipe_reg_chain_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               STAGES     = 4,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = WIDTH'(RV_NOP),
  parameter int               CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [STAGES-1:0]       stall,
  input  logic [STAGES-1:0]       flush,
  input  logic                    cnt_clr,
  output logic [STAGES*WIDTH-1:0] tap_data,
  output logic [STAGES-1:0]       tap_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [STAGES-1:0][WIDTH-1:0] data_r;
  logic [STAGES-1:0]            valid_r;
  logic [STAGES-1:0]            hold_s;
  stage_sel_e                   sel_s       [STAGES];
  logic [WIDTH-1:0]             src_data_s  [STAGES];
  logic                         src_valid_s [STAGES];
  logic                         last_nxt_valid_s;
  logic                         stall_inc_s;
  logic                         bubble_inc_s;

  // hold[i] is the OR of stall[i] and every downstream stall request.
  always_comb begin
    hold_s = {STAGES{1'b0}};
    for (int i = 0; i < STAGES; i++) begin
      for (int j = i; j < STAGES; j++) begin
        hold_s[i] = hold_s[i] | stall[j];
      end
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic up_hold_s;

    if (g == 0) begin : g_first
      assign src_data_s[g]  = in_data;
      assign src_valid_s[g] = in_valid;
      assign up_hold_s      = 1'b0;
    end else begin : g_rest
      assign src_data_s[g]  = data_r[g-1];
      assign src_valid_s[g] = valid_r[g-1];
      // Upstream frozen while this stage moves on: fill the gap with a bubble.
      assign up_hold_s      = hold_s[g-1];
    end

    // Priority select: flush, then hold, then auto-bubble, then load.
    always_comb begin
      sel_s[g] = SEL_LOAD;
      if (flush[g]) begin
        sel_s[g] = SEL_BUBBLE;
      end else if (hold_s[g]) begin
        sel_s[g] = SEL_HOLD;
      end else if (up_hold_s) begin
        sel_s[g] = SEL_BUBBLE;
      end else begin
        sel_s[g] = SEL_LOAD;
      end
    end

    pipe_reg_chain_stage #(
      .WIDTH      (WIDTH),
      .BUBBLE_VAL (BUBBLE_VAL)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .sel       (sel_s[g]),
      .src_data  (src_data_s[g]),
      .src_valid (src_valid_s[g]),
      .data      (data_r[g]),
      .valid     (valid_r[g])
    );
  end

  // Valid bit the last stage will capture at the coming edge.
  always_comb begin
    last_nxt_valid_s = 1'b0;
    case (sel_s[STAGES-1])
      SEL_LOAD:   last_nxt_valid_s = src_valid_s[STAGES-1];
      SEL_HOLD:   last_nxt_valid_s = valid_r[STAGES-1];
      SEL_BUBBLE: last_nxt_valid_s = 1'b0;
      default:    last_nxt_valid_s = 1'b0;
    endcase
  end

  assign stall_inc_s  = hold_s[0];
  assign bubble_inc_s = ~hold_s[STAGES-1] & ~last_nxt_valid_s;

  // Saturating performance counters; clear wins over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt  <= {CNT_W{1'b0}};
      bubble_cnt <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      stall_cnt  <= {CNT_W{1'b0}};
      bubble_cnt <= {CNT_W{1'b0}};
    end else begin
      if (stall_inc_s && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end else begin
        stall_cnt <= stall_cnt;
      end
      if (bubble_inc_s && (bubble_cnt != CNT_MAX)) begin
        bubble_cnt <= bubble_cnt + CNT_ONE;
      end else begin
        bubble_cnt <= bubble_cnt;
      end
    end
  end

  assign in_ready  = ~hold_s[0];
  assign tap_data  = data_r;
  assign tap_valid = valid_r;
  assign out_data  = data_r[STAGES-1];
  assign out_valid = valid_r[STAGES-1];

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed self-checking bench for pipe_reg_chain: one default instance
// (4 stages, 16-bit counters) and one with 3-bit counters for saturation.
module tb_pipe_reg_chain;

  localparam int W = 32;
  localparam int S = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic           clk;
  logic           reset;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [S-1:0]   stall;
  logic [S-1:0]   flush;
  logic           cnt_clr;
  logic [S*W-1:0] tap_data;
  logic [S-1:0]   tap_valid;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic [15:0]    stall_cnt;
  logic [15:0]    bubble_cnt;

  logic           sat_in_ready;
  logic [S-1:0]   sat_stall;
  logic           sat_cnt_clr;
  logic [S*W-1:0] sat_tap_data;
  logic [S-1:0]   sat_tap_valid;
  logic [W-1:0]   sat_out_data;
  logic           sat_out_valid;
  logic [2:0]     sat_stall_cnt;
  logic [2:0]     sat_bubble_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pipe_reg_chain #(.WIDTH(W), .STAGES(S), .CNT_W(16)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .stall      (stall),
    .flush      (flush),
    .cnt_clr    (cnt_clr),
    .tap_data   (tap_data),
    .tap_valid  (tap_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  pipe_reg_chain #(.WIDTH(W), .STAGES(S), .CNT_W(3)) u_sat (
    .clk        (clk),
    .reset      (reset),
    .in_data    (32'h0000_0000),
    .in_valid   (1'b0),
    .in_ready   (sat_in_ready),
    .stall      (sat_stall),
    .flush      (4'b0000),
    .cnt_clr    (sat_cnt_clr),
    .tap_data   (sat_tap_data),
    .tap_valid  (sat_tap_valid),
    .out_data   (sat_out_data),
    .out_valid  (sat_out_valid),
    .stall_cnt  (sat_stall_cnt),
    .bubble_cnt (sat_bubble_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] stage_of(input logic [S*W-1:0] taps, input int i);
    return taps[i*W +: W];
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    in_data     = 32'h0;
    in_valid    = 1'b0;
    stall       = 4'b0000;
    flush       = 4'b0000;
    cnt_clr     = 1'b0;
    sat_stall   = 4'b0000;
    sat_cnt_clr = 1'b0;
    #12;
    // reset state
    chk("rst_valid", tap_valid, 4'b0000);
    chk("rst_out", out_data, NOP);
    chk("rst_s0", stage_of(tap_data, 0), NOP);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_scnt", stall_cnt, 16'd0);
    chk("rst_bcnt", bubble_cnt, 16'd0);
    reset = 1'b0;

    // fill: latency of 4 edges, bubbles counted until valid data arrives
    in_valid = 1'b1;
    in_data = 32'h11; tick();
    in_data = 32'h22; tick();
    in_data = 32'h33; tick();
    chk("fill_bcnt3", bubble_cnt, 16'd3);
    chk("fill_nout", out_valid, 1'b0);
    in_data = 32'h44; tick();
    chk("fill_o11", out_data, 32'h11);
    chk("fill_v11", out_valid, 1'b1);
    in_valid = 1'b0; in_data = 32'h0;
    tick(); chk("fill_o22", out_data, 32'h22);
    tick(); chk("fill_o33", out_data, 32'h33);
    tick(); chk("fill_o44", out_data, 32'h44);
    chk("fill_bcnt_end", bubble_cnt, 16'd3);

    // async reset between edges takes effect immediately
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", tap_valid, 4'b0000);
    chk("arst_out", out_data, NOP);
    chk("arst_s1", stage_of(tap_data, 1), NOP);
    chk("arst_bcnt", bubble_cnt, 16'd0);
    chk("arst_scnt", stall_cnt, 16'd0);
    reset = 1'b0;

    // stall in the middle of a stream
    in_valid = 1'b1;
    in_data = 32'hA0; tick();
    in_data = 32'hA1; tick();
    in_data = 32'hA2; tick();
    in_data = 32'hA3; tick();
    in_data = 32'hA4; stall = 4'b0100;
    #1;
    chk("stl_ready", in_ready, 1'b0);
    tick();
    chk("stl_out1", out_data, NOP);
    chk("stl_vout1", out_valid, 1'b0);
    chk("stl_scnt1", stall_cnt, 16'd1);
    tick();
    chk("stl_s0", stage_of(tap_data, 0), 32'hA3);
    chk("stl_s1", stage_of(tap_data, 1), 32'hA2);
    chk("stl_s2", stage_of(tap_data, 2), 32'hA1);
    chk("stl_valid", tap_valid, 4'b0111);
    chk("stl_scnt2", stall_cnt, 16'd2);
    chk("stl_bcnt", bubble_cnt, 16'd5);
    stall = 4'b0000;
    tick(); chk("stl_oA1", out_data, 32'hA1);
    in_data = 32'hA5;
    tick(); chk("stl_oA2", out_data, 32'hA2);
    in_valid = 1'b0;
    tick(); chk("stl_oA3", out_data, 32'hA3);
    tick(); chk("stl_oA4", out_data, 32'hA4);
    tick(); chk("stl_oA5", out_data, 32'hA5);
    chk("stl_vA5", out_valid, 1'b1);
    chk("stl_ready2", in_ready, 1'b1);
    chk("stl_bcnt_end", bubble_cnt, 16'd5);
    chk("stl_scnt_end", stall_cnt, 16'd2);

    // flush beats stall on the same stage
    do_reset();
    in_valid = 1'b1;
    in_data = 32'hB0; tick();
    in_data = 32'hB1; tick();
    in_data = 32'hB2; tick();
    in_data = 32'hB3; stall = 4'b0010; flush = 4'b0010;
    tick();
    stall = 4'b0000; flush = 4'b0000;
    chk("fvs_valid", tap_valid, 4'b1001);
    chk("fvs_s0", stage_of(tap_data, 0), 32'hB2);
    chk("fvs_s1", stage_of(tap_data, 1), NOP);
    chk("fvs_s2", stage_of(tap_data, 2), NOP);
    chk("fvs_s3", stage_of(tap_data, 3), 32'hB0);
    chk("fvs_scnt", stall_cnt, 16'd1);
    chk("fvs_bcnt", bubble_cnt, 16'd3);

    // branch flush of the two front stages
    do_reset();
    in_valid = 1'b1;
    in_data = 32'hC0; tick();
    in_data = 32'hC1; tick();
    in_data = 32'hC2; tick();
    in_data = 32'hC3; tick();
    in_data = 32'hC4; flush = 4'b0011;
    tick();
    flush = 4'b0000; in_valid = 1'b0;
    chk("brf_valid", tap_valid, 4'b1100);
    chk("brf_s0", stage_of(tap_data, 0), NOP);
    chk("brf_s1", stage_of(tap_data, 1), NOP);
    chk("brf_s2", stage_of(tap_data, 2), 32'hC2);
    chk("brf_s3", stage_of(tap_data, 3), 32'hC1);
    chk("brf_scnt", stall_cnt, 16'd0);

    // counter saturation with 3-bit counters, then clear
    do_reset();
    sat_stall = 4'b0001;
    for (int k = 0; k < 10; k++) tick();
    chk("sat_scnt", sat_stall_cnt, 3'd7);
    chk("sat_bcnt", sat_bubble_cnt, 3'd7);
    chk("sat_ready", sat_in_ready, 1'b0);
    sat_cnt_clr = 1'b1;
    tick();
    chk("sat_clr_s", sat_stall_cnt, 3'd0);
    chk("sat_clr_b", sat_bubble_cnt, 3'd0);
    sat_cnt_clr = 1'b0; sat_stall = 4'b0000;
    tick();
    chk("sat_idle_s", sat_stall_cnt, 3'd0);
    chk("sat_idle_b", sat_bubble_cnt, 3'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
